// File: rtl/dnn_rd_addr_checker.sv
// -----------------------------------------------------------------------------
// dnn_rd_addr_checker
//
// In-system monitor for the DNN accelerator read-request channel. A small
// descriptor table (written through cfg_wr_*) describes the expected sequence
// of read addresses: each descriptor is {type, base, stride, size, loop_max}
// and covers loop_max+1 requests at base, base+stride, base+2*stride, ...
// Every rd_req seen during a run is compared with the expected address; the
// block keeps a saturating error count and sticky pass/fail flags, and fails
// the run if done does not arrive within TIMEOUT busy cycles.
//
// Optional feature macro: RD_SIZE_CHECK_EN
//    defined   : rd_req_size_i is also compared with the descriptor size field
//    undefined : rd_req_size_i and the size field are ignored
//
// Ports
//    clk_i             clock
//    reset_i           synchronous active-high reset (table contents kept)
//    start_i           pulse: clear status and begin a run
//    done_i            pulse: accelerator finished, resolve pass/fail
//    rd_req_i          read request strobe
//    rd_addr_i         read request address
//    rd_req_size_i     read request size
//    cfg_wr_en_i       descriptor table write strobe
//    cfg_wr_addr_i     descriptor table write index
//    cfg_wr_data_i     descriptor, MSB..LSB {type, base, stride, size, loop_max}
//    cfg_num_entries_i number of valid descriptors
//    curr_idx_o        active descriptor index
//    exp_addr_o        expected address for the next request
//    err_count_o       mismatches since start, saturating
//    pass_o / fail_o   sticky run result
// -----------------------------------------------------------------------------
module dnn_rd_addr_checker #(
   parameter int          ADDR_W        = 32,
   parameter int          BASE_ADDR_W   = ADDR_W,
   parameter int          OFFSET_ADDR_W = ADDR_W,
   parameter int          TX_SIZE_WIDTH = 20,
   parameter int          RD_LOOP_W     = 10,
   parameter int          D_TYPE_W      = 1,
   parameter int          ROM_ADDR_W    = 10,
   parameter int unsigned TIMEOUT       = 100000,
   localparam int         ROM_WIDTH     = D_TYPE_W + BASE_ADDR_W + OFFSET_ADDR_W
                                          + TX_SIZE_WIDTH + RD_LOOP_W
) (
   input  logic                     clk_i,
   input  logic                     reset_i,
   input  logic                     start_i,
   input  logic                     done_i,
   input  logic                     rd_req_i,
   input  logic [ADDR_W-1:0]        rd_addr_i,
   input  logic [TX_SIZE_WIDTH-1:0] rd_req_size_i,
   input  logic                     cfg_wr_en_i,
   input  logic [ROM_ADDR_W-1:0]    cfg_wr_addr_i,
   input  logic [ROM_WIDTH-1:0]     cfg_wr_data_i,
   input  logic [ROM_ADDR_W:0]      cfg_num_entries_i,
   output logic [ROM_ADDR_W:0]      curr_idx_o,
   output logic [ADDR_W-1:0]        exp_addr_o,
   output logic [15:0]              err_count_o,
   output logic                     pass_o,
   output logic                     fail_o
);

   localparam int DEPTH    = 1 << ROM_ADDR_W;
   localparam int LOOP_LSB = 0;
   localparam int SIZE_LSB = LOOP_LSB + RD_LOOP_W;
   localparam int OFF_LSB  = SIZE_LSB + TX_SIZE_WIDTH;
   localparam int BASE_LSB = OFF_LSB + OFFSET_ADDR_W;
   localparam int TYPE_LSB = BASE_LSB + BASE_ADDR_W;

   // Saturating increment for the 16-bit error counter.
   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      logic [15:0] r;
      if (v == 16'hFFFF) begin
         r = v;
      end else begin
         r = v + 16'd1;
      end
      return r;
   endfunction

   // Descriptor table and run state
   logic [ROM_WIDTH-1:0]     table_q [DEPTH];
   logic [ROM_ADDR_W:0]      idx_q,    idx_d;
   logic [ADDR_W-1:0]        offset_q, offset_d;
   logic [RD_LOOP_W-1:0]     count_q,  count_d;
   logic [31:0]              timer_q,  timer_d;
   logic [15:0]              err_q,    err_d;
   logic                     pass_q,   pass_d;
   logic                     fail_q,   fail_d;
   logic                     busy_q,   busy_d;
   // armed_q keeps exp_addr at zero from reset until the first start.
   logic                     armed_q,  armed_d;

   // Current descriptor fields
   logic [ROM_WIDTH-1:0]     desc_s;
   logic [D_TYPE_W-1:0]      type_s;
   logic [BASE_ADDR_W-1:0]   base_s;
   logic [OFFSET_ADDR_W-1:0] stride_s;
   logic [TX_SIZE_WIDTH-1:0] size_s;
   logic [RD_LOOP_W-1:0]     loop_s;
   logic [ADDR_W-1:0]        base_ext_s;
   logic [ADDR_W-1:0]        stride_ext_s;
   logic [ADDR_W-1:0]        exp_addr_s;
   logic                     in_range_s;
   logic                     size_err_s;
   logic                     mismatch_s;
   logic                     unused_s;

   // Descriptor table write port; contents survive reset.
   always_ff @(posedge clk_i) begin
      if (cfg_wr_en_i) begin
         table_q[cfg_wr_addr_i] <= cfg_wr_data_i;
      end
   end

   // Combinational lookup: an index beyond the table depth only happens on
   // overrun, where the looked-up value is never used for advancing.
   assign desc_s   = table_q[idx_q[ROM_ADDR_W-1:0]];
   assign type_s   = desc_s[TYPE_LSB +: D_TYPE_W];
   assign base_s   = desc_s[BASE_LSB +: BASE_ADDR_W];
   assign stride_s = desc_s[OFF_LSB  +: OFFSET_ADDR_W];
   assign size_s   = desc_s[SIZE_LSB +: TX_SIZE_WIDTH];
   assign loop_s   = desc_s[LOOP_LSB +: RD_LOOP_W];

   assign base_ext_s   = ADDR_W'(base_s);
   assign stride_ext_s = ADDR_W'(stride_s);
   assign exp_addr_s   = base_ext_s + offset_q;
   assign in_range_s   = (idx_q < cfg_num_entries_i);

`ifdef RD_SIZE_CHECK_EN
   assign size_err_s = (rd_req_size_i != size_s);
   assign unused_s   = ^type_s;
`else
   assign size_err_s = 1'b0;
   assign unused_s   = ^{type_s, size_s, rd_req_size_i};
`endif

   // A request past the last valid descriptor is always an error.
   assign mismatch_s = !in_range_s || (rd_addr_i != exp_addr_s) || size_err_s;

   // Next-state logic: start dominates, then request handling, then done/timeout.
   always_comb begin
      idx_d    = idx_q;
      offset_d = offset_q;
      count_d  = count_q;
      timer_d  = timer_q;
      err_d    = err_q;
      pass_d   = pass_q;
      fail_d   = fail_q;
      busy_d   = busy_q;
      armed_d  = armed_q;

      if (start_i) begin
         idx_d    = {(ROM_ADDR_W+1){1'b0}};
         offset_d = {ADDR_W{1'b0}};
         count_d  = {RD_LOOP_W{1'b0}};
         timer_d  = 32'd0;
         err_d    = 16'd0;
         pass_d   = 1'b0;
         fail_d   = 1'b0;
         busy_d   = 1'b1;
         armed_d  = 1'b1;
      end else if (busy_q) begin
         if (rd_req_i) begin
            if (mismatch_s) begin
               err_d  = sat_inc16(err_q);
               fail_d = 1'b1;
            end else begin
               err_d  = err_q;
            end
            if (in_range_s) begin
               if (count_q == loop_s) begin
                  offset_d = {ADDR_W{1'b0}};
                  count_d  = {RD_LOOP_W{1'b0}};
                  idx_d    = idx_q + {{ROM_ADDR_W{1'b0}}, 1'b1};
               end else begin
                  offset_d = offset_q + stride_ext_s;
                  count_d  = count_q + {{(RD_LOOP_W-1){1'b0}}, 1'b1};
               end
            end else begin
               idx_d = idx_q;
            end
         end else begin
            err_d = err_q;
         end

         // Done sees the effect of a same-cycle request (err_d/fail_d/idx_d).
         if (done_i) begin
            busy_d = 1'b0;
            if ((err_d == 16'd0) && !fail_d && (idx_d == cfg_num_entries_i)) begin
               pass_d = 1'b1;
            end else begin
               fail_d = 1'b1;
            end
         end else if (timer_q == 32'(TIMEOUT)) begin
            fail_d = 1'b1;
            busy_d = 1'b0;
         end else begin
            timer_d = timer_q + 32'd1;
         end
      end else begin
         busy_d = 1'b0;
      end
   end

   // Run-state registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         idx_q    <= {(ROM_ADDR_W+1){1'b0}};
         offset_q <= {ADDR_W{1'b0}};
         count_q  <= {RD_LOOP_W{1'b0}};
         timer_q  <= 32'd0;
         err_q    <= 16'd0;
         pass_q   <= 1'b0;
         fail_q   <= 1'b0;
         busy_q   <= 1'b0;
         armed_q  <= 1'b0;
      end else begin
         idx_q    <= idx_d;
         offset_q <= offset_d;
         count_q  <= count_d;
         timer_q  <= timer_d;
         err_q    <= err_d;
         pass_q   <= pass_d;
         fail_q   <= fail_d;
         busy_q   <= busy_d;
         armed_q  <= armed_d;
      end
   end

   assign curr_idx_o  = idx_q;
   assign exp_addr_o  = armed_q ? exp_addr_s : {ADDR_W{1'b0}};
   assign err_count_o = err_q;
   assign pass_o      = pass_q;
   assign fail_o      = fail_q;

endmodule

// File: tb/tb_dnn_rd_addr_checker.sv
// -----------------------------------------------------------------------------
// Testbench for dnn_rd_addr_checker: vector table for the directed scenarios,
// hand-written sequences for timeout / reset / size check, and randomized runs
// compared against a flattened expected-address list.
// -----------------------------------------------------------------------------
module tb_dnn_rd_addr_checker;

   localparam int AW    = 32;
   localparam int RAW   = 10;
   localparam int TXW   = 20;
   localparam int LW    = 10;
   localparam int ROM_W = 1 + 32 + 32 + TXW + LW;
   localparam int TMO   = 50;

   logic             clk;
   logic             reset;
   logic             start;
   logic             done;
   logic             rd_req;
   logic [AW-1:0]    rd_addr;
   logic [TXW-1:0]   rd_req_size;
   logic             cfg_wr_en;
   logic [RAW-1:0]   cfg_wr_addr;
   logic [ROM_W-1:0] cfg_wr_data;
   logic [RAW:0]     cfg_num_entries;
   logic [RAW:0]     curr_idx;
   logic [AW-1:0]    exp_addr;
   logic [15:0]      err_count;
   logic             pass;
   logic             fail;

   int n_chk  = 0;
   int n_pass = 0;

   dnn_rd_addr_checker #(.TIMEOUT(TMO)) dut (
      .clk_i             (clk),
      .reset_i           (reset),
      .start_i           (start),
      .done_i            (done),
      .rd_req_i          (rd_req),
      .rd_addr_i         (rd_addr),
      .rd_req_size_i     (rd_req_size),
      .cfg_wr_en_i       (cfg_wr_en),
      .cfg_wr_addr_i     (cfg_wr_addr),
      .cfg_wr_data_i     (cfg_wr_data),
      .cfg_num_entries_i (cfg_num_entries),
      .curr_idx_o        (curr_idx),
      .exp_addr_o        (exp_addr),
      .err_count_o       (err_count),
      .pass_o            (pass),
      .fail_o            (fail)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        st;
      logic        rd;
      logic        dn;
      logic [31:0] addr;
      logic [10:0] num;
      logic [10:0] e_idx;
      logic        chk_addr;
      logic [31:0] e_addr;
      logic [15:0] e_err;
      logic        e_pass;
      logic        e_fail;
   } vec_t;

   vec_t vecs[$];

   // random-model state
   logic [31:0] q_addr[$];
   int          q_desc[$];

   function automatic logic [ROM_W-1:0] pack(input logic [31:0] base, input logic [31:0] stride,
                                             input logic [19:0] size, input logic [9:0] lmax);
      return {1'b0, base, stride, size, lmax};
   endfunction

   function automatic void add(input logic st, input logic rd, input logic dn, input logic [31:0] addr,
                               input logic [10:0] num, input logic [10:0] e_idx, input logic chk_addr,
                               input logic [31:0] e_addr, input logic [15:0] e_err,
                               input logic e_pass, input logic e_fail);
      vec_t v;
      v.st = st; v.rd = rd; v.dn = dn; v.addr = addr; v.num = num;
      v.e_idx = e_idx; v.chk_addr = chk_addr; v.e_addr = e_addr;
      v.e_err = e_err; v.e_pass = e_pass; v.e_fail = e_fail;
      vecs.push_back(v);
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_chk++;
      if (act === req) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
      end
   endtask

   task automatic wr_desc(input int idx, input logic [ROM_W-1:0] d);
      cfg_wr_en   = 1'b1;
      cfg_wr_addr = RAW'(idx);
      cfg_wr_data = d;
      @(negedge clk);
      cfg_wr_en   = 1'b0;
   endtask

   task automatic run_vectors(input int lo, input int hi);
      for (int i = lo; i <= hi; i++) begin
         start           = vecs[i].st;
         rd_req          = vecs[i].rd;
         done            = vecs[i].dn;
         rd_addr         = vecs[i].addr;
         cfg_num_entries = vecs[i].num;
         @(negedge clk);
         chk($sformatf("vec%0d idx", i),  64'(curr_idx),  64'(vecs[i].e_idx));
         chk($sformatf("vec%0d err", i),  64'(err_count), 64'(vecs[i].e_err));
         chk($sformatf("vec%0d pass", i), 64'(pass),      64'(vecs[i].e_pass));
         chk($sformatf("vec%0d fail", i), 64'(fail),      64'(vecs[i].e_fail));
         if (vecs[i].chk_addr) begin
            chk($sformatf("vec%0d exp_addr", i), 64'(exp_addr), 64'(vecs[i].e_addr));
         end
      end
      start  = 1'b0;
      rd_req = 1'b0;
      done   = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   initial begin
      int first;
      int total;
      int num;
      int k;
      int nrd;
      int errs;
      logic [31:0] base;
      logic [31:0] stride;
      logic [31:0] a;
      int lmax;
      logic mism;
      logic ok_addr;
      logic exp_ok;

      reset = 1'b1; start = 1'b0; done = 1'b0; rd_req = 1'b0; rd_addr = 32'd0;
      rd_req_size = 20'd64; cfg_wr_en = 1'b0; cfg_wr_addr = '0; cfg_wr_data = '0;
      cfg_num_entries = 11'd1;

      // Segment A: single descriptor, clean run then one bad address
      add(1,0,0,32'h0,  1, 0,1,32'h100,0,0,0);
      add(0,1,0,32'h100,1, 0,1,32'h110,0,0,0);
      add(0,1,0,32'h110,1, 0,1,32'h120,0,0,0);
      add(0,1,0,32'h120,1, 0,1,32'h130,0,0,0);
      add(0,1,0,32'h130,1, 1,0,32'h0,  0,0,0);
      add(0,0,1,32'h0,  1, 1,0,32'h0,  0,1,0);
      add(1,0,0,32'h0,  1, 0,1,32'h100,0,0,0);
      add(0,1,0,32'h100,1, 0,1,32'h110,0,0,0);
      add(0,1,0,32'h114,1, 0,1,32'h120,1,0,1);
      add(0,1,0,32'h120,1, 0,1,32'h130,1,0,1);
      add(0,1,0,32'h130,1, 1,0,32'h0,  1,0,1);
      add(0,0,1,32'h0,  1, 1,0,32'h0,  1,0,1);
      // Segment B: two descriptors, overrun, start/done collisions
      add(1,0,0,32'h0,  2, 0,1,32'h200,0,0,0);
      add(0,1,0,32'h200,2, 1,1,32'h400,0,0,0);
      add(0,1,0,32'h400,2, 1,1,32'h408,0,0,0);
      add(0,1,0,32'h408,2, 2,1,32'h800,0,0,0);
      add(0,0,1,32'h0,  2, 2,1,32'h800,0,1,0);
      add(1,0,0,32'h0,  1, 0,1,32'h200,0,0,0);
      add(0,1,0,32'h200,1, 1,1,32'h400,0,0,0);
      add(0,1,0,32'h400,1, 1,1,32'h400,1,0,1);
      add(0,0,1,32'h0,  1, 1,1,32'h400,1,0,1);
      add(1,1,1,32'h999,1, 0,1,32'h200,0,0,0);
      add(0,1,1,32'h200,1, 1,1,32'h400,0,1,0);
      add(1,0,0,32'h0,  1, 0,1,32'h200,0,0,0);
      add(0,1,1,32'h201,1, 1,1,32'h400,1,0,1);
      add(0,1,0,32'h400,1, 1,1,32'h400,1,0,1);

      repeat (3) @(negedge clk);
      reset = 1'b0;
      chk("rst idx",  64'(curr_idx),  64'd0);
      chk("rst addr", 64'(exp_addr),  64'd0);
      chk("rst err",  64'(err_count), 64'd0);
      chk("rst pass", 64'(pass),      64'd0);
      chk("rst fail", 64'(fail),      64'd0);

      wr_desc(0, pack(32'h100, 32'h10, 20'd64, 10'd3));
      run_vectors(0, 11);
      wr_desc(0, pack(32'h200, 32'h4, 20'd64, 10'd0));
      wr_desc(1, pack(32'h400, 32'h8, 20'd64, 10'd1));
      wr_desc(2, pack(32'h800, 32'h0, 20'd64, 10'd0));
      run_vectors(12, vecs.size() - 1);

      // Timeout: fail exactly TMO+1 edges after the start edge
      cfg_num_entries = 11'd1;
      pulse_start();
      first = -1;
      for (int c = 1; c <= 200 && first < 0; c++) begin
         @(negedge clk);
         if (fail) first = c;
      end
      chk("timeout cycle", 64'(first), 64'(TMO + 1));
      chk("timeout pass",  64'(pass),  64'd0);
      // run has ended: a bad request must be ignored
      rd_req = 1'b1; rd_addr = 32'hDEAD_BEEF;
      @(negedge clk);
      rd_req = 1'b0;
      chk("post-timeout err", 64'(err_count), 64'd0);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("rst2 pass", 64'(pass),      64'd0);
      chk("rst2 fail", 64'(fail),      64'd0);
      chk("rst2 err",  64'(err_count), 64'd0);

      // Reset aborts a run with errors; reset overrides start
      pulse_start();
      rd_req = 1'b1; rd_addr = 32'h1234;
      @(negedge clk);
      rd_req = 1'b0;
      chk("abort pre err", 64'(err_count), 64'd1);
      reset = 1'b1; start = 1'b1;
      @(negedge clk);
      reset = 1'b0; start = 1'b0;
      rd_req = 1'b1; rd_addr = 32'h5678;
      @(negedge clk);
      rd_req = 1'b0;
      chk("abort err",  64'(err_count), 64'd0);
      chk("abort fail", 64'(fail),      64'd0);
      chk("abort addr", 64'(exp_addr),  64'd0);

      // Size field 64, request size 32, correct address
      wr_desc(0, pack(32'h300, 32'h4, 20'd64, 10'd0));
      cfg_num_entries = 11'd1;
      pulse_start();
      rd_req = 1'b1; rd_addr = 32'h300; rd_req_size = 20'd32;
      @(negedge clk);
      rd_req = 1'b0; rd_req_size = 20'd64;
      done = 1'b1;
      @(negedge clk);
      done = 1'b0;
`ifdef RD_SIZE_CHECK_EN
      chk("size err",  64'(err_count), 64'd1);
      chk("size fail", 64'(fail),      64'd1);
      chk("size pass", 64'(pass),      64'd0);
`else
      chk("size err",  64'(err_count), 64'd0);
      chk("size fail", 64'(fail),      64'd0);
      chk("size pass", 64'(pass),      64'd1);
`endif

      // Randomized runs against a flattened list of expected addresses
      for (int r = 0; r < 40; r++) begin
         q_addr.delete();
         q_desc.delete();
         num = int'($urandom_range(1, 4));
         for (int e = 0; e < num; e++) begin
            base   = $urandom;
            stride = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 64)) : $urandom;
            lmax   = int'($urandom_range(0, 3));
            wr_desc(e, pack(base, stride, 20'd64, 10'(lmax)));
            for (int j = 0; j <= lmax; j++) begin
               a = base + stride * 32'(j);
               q_addr.push_back(a);
               q_desc.push_back(e);
            end
         end
         total = q_addr.size();
         cfg_num_entries = 11'(num);
         pulse_start();
         chk($sformatf("rnd%0d start idx", r), 64'(curr_idx), 64'd0);
         chk($sformatf("rnd%0d start addr", r), 64'(exp_addr), 64'(q_addr[0]));
         k = 0;
         errs = 0;
         nrd = total + int'($urandom_range(0, 2));
         for (int n = 0; n < nrd; n++) begin
            if ($urandom_range(0, 3) == 0) @(negedge clk);
            ok_addr = ($urandom_range(0, 7) != 0);
            rd_addr = (k < total && ok_addr) ? q_addr[k] : $urandom;
            rd_req  = 1'b1;
            mism    = (k >= total) || (rd_addr != q_addr[k]);
            if (mism && errs < 16'hFFFF) errs++;
            if (k < total) k++;
            @(negedge clk);
            rd_req = 1'b0;
            chk($sformatf("rnd%0d.%0d idx", r, n), 64'(curr_idx),
                (k < total) ? 64'(q_desc[k]) : 64'(num));
            chk($sformatf("rnd%0d.%0d err", r, n), 64'(err_count), 64'(errs));
            if (k < total) begin
               chk($sformatf("rnd%0d.%0d addr", r, n), 64'(exp_addr), 64'(q_addr[k]));
            end
         end
         done = 1'b1;
         @(negedge clk);
         done = 1'b0;
         exp_ok = (errs == 0) && (k == total);
         chk($sformatf("rnd%0d pass", r), 64'(pass), 64'(exp_ok));
         chk($sformatf("rnd%0d fail", r), 64'(fail), 64'(!exp_ok));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
